// File: rtl/bcd_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_scan_display
//  Description : Converts two 6-bit binary fields (high/low, e.g. minutes and
//                seconds) into four BCD digits with a sequential shift-add-3
//                engine, then time-multiplexes the digits onto a single
//                active-low 7-segment bus.
//  Ports       : clk        - system clock, rising edge
//                clear      - synchronous active-high reset
//                value_hi   - binary count shown on digits 3..2
//                value_lo   - binary count shown on digits 1..0
//                dp_en      - lights the decimal point of digit 2
//                an         - digit enables, active low, one-hot-low
//                seg        - cathodes, active low, seg[0]=a .. seg[6]=g
//                dp         - decimal point, active low
//                digits     - {hi_tens, hi_ones, lo_tens, lo_ones}
//                conv_done  - one-cycle pulse when digits is updated
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_scan_display #(
    parameter int SCAN_DIV = 50000,
    parameter int WIDTH    = 6
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] value_hi,
    input  logic [WIDTH-1:0] value_lo,
    input  logic             dp_en,
    output logic [3:0]       an,
    output logic [6:0]       seg,
    output logic             dp,
    output logic [15:0]      digits,
    output logic             conv_done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_LOAD   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;

    localparam logic [2:0] ITER_LAST = 3'(WIDTH - 1);

    localparam int               CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

    localparam logic [6:0] GLYPH_ZERO = 7'b1000000;

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------
    // Double-dabble correction: any BCD nibble of 5 or more gets +3 so that
    // the following left shift carries correctly into the next decade.
    function automatic logic [7:0] add3(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
        if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
        return r;
    endfunction

    // Active-low gfedcba decode; codes 10..15 cannot occur but are blanked.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]       state_q,    state_d;
    logic [2:0]       iter_q,     iter_d;
    logic [WIDTH-1:0] bin_hi_q,   bin_hi_d;
    logic [WIDTH-1:0] bin_lo_q,   bin_lo_d;
    logic [7:0]       bcd_hi_q,   bcd_hi_d;
    logic [7:0]       bcd_lo_q,   bcd_lo_d;
    logic [15:0]      digits_q,   digits_d;
    logic             done_q,     done_d;
    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]       idx_q,      idx_d;
    logic [3:0]       an_q,       an_d;
    logic [6:0]       seg_q,      seg_d;
    logic             dp_q,       dp_d;

    logic [7:0]       w_adj_hi;
    logic [7:0]       w_adj_lo;
    logic [3:0]       w_sel_digit;

    assign w_adj_hi = add3(bcd_hi_q);
    assign w_adj_lo = add3(bcd_lo_q);

    // ------------------------------------------------------------------------
    // Conversion FSM: LOAD (1) -> SHIFT (WIDTH) -> UPDATE (1) -> LOAD ...
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        iter_d   = iter_q;
        bin_hi_d = bin_hi_q;
        bin_lo_d = bin_lo_q;
        bcd_hi_d = bcd_hi_q;
        bcd_lo_d = bcd_lo_q;
        digits_d = digits_q;
        done_d   = 1'b0;

        case (state_q)
            S_LOAD: begin
                bin_hi_d = value_hi;
                bin_lo_d = value_lo;
                bcd_hi_d = '0;
                bcd_lo_d = '0;
                iter_d   = '0;
                state_d  = S_SHIFT;
            end
            S_SHIFT: begin
                // The MSB of the binary operand shifts into the scratch LSB.
                {bcd_hi_d, bin_hi_d} = {w_adj_hi, bin_hi_q} << 1;
                {bcd_lo_d, bin_lo_d} = {w_adj_lo, bin_lo_q} << 1;
                if (iter_q == ITER_LAST) begin
                    iter_d  = '0;
                    state_d = S_UPDATE;
                end else begin
                    iter_d  = iter_q + 3'd1;
                end
            end
            S_UPDATE: begin
                digits_d = {bcd_hi_q, bcd_lo_q};
                done_d   = 1'b1;
                state_d  = S_LOAD;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Scan timing and registered display outputs
    // ------------------------------------------------------------------------
    always_comb begin
        scan_cnt_d = scan_cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end
    end

    always_comb begin
        case (idx_q)
            2'd0:    w_sel_digit = digits_q[3:0];
            2'd1:    w_sel_digit = digits_q[7:4];
            2'd2:    w_sel_digit = digits_q[11:8];
            default: w_sel_digit = digits_q[15:12];
        endcase
    end

    // an, seg and dp are all derived from the same idx_q/digits_q and load on
    // the same edge, so the bus never shows one digit's glyph on another's
    // enable.
    always_comb begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = seg_decode(w_sel_digit);
        dp_d  = ~((idx_q == 2'd2) & dp_en);
    end

    // ------------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q    <= S_LOAD;
            iter_q     <= '0;
            bin_hi_q   <= '0;
            bin_lo_q   <= '0;
            bcd_hi_q   <= '0;
            bcd_lo_q   <= '0;
            digits_q   <= '0;
            done_q     <= 1'b0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            an_q       <= 4'b1110;
            seg_q      <= GLYPH_ZERO;
            dp_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            iter_q     <= iter_d;
            bin_hi_q   <= bin_hi_d;
            bin_lo_q   <= bin_lo_d;
            bcd_hi_q   <= bcd_hi_d;
            bcd_lo_q   <= bcd_lo_d;
            digits_q   <= digits_d;
            done_q     <= done_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign digits    = digits_q;
    assign conv_done = done_q;

endmodule
`default_nettype wire

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Consumes the 6-bit binary counts produced by the counter stage: a high field (e.g. minutes) and a low field (e.g. seconds).
- Converts each field to two BCD digits with a sequential shift-add-3 engine.
- Time-multiplexes the four digits onto one active-low 7-segment bus.
- Sits between the counter chain and the board's 4-digit display pins.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit stays lit before the scan advances (min 2).
- WIDTH, 6, width of each binary input field (fixed at 6 for this block; max value 63).

Ports:
- clk  input  1  system clock, all logic on rising edge
- clear  input  1  synchronous active-high reset
- value_hi  input  6  binary count shown on digits 3..2
- value_lo  input  6  binary count shown on digits 1..0
- dp_en  input  1  lights the decimal point of digit 2 (hi/lo separator)
- an  output  4  digit enables, active low, one-hot-low
- seg  output  7  cathodes, active low, seg[0]=a .. seg[6]=g
- dp  output  1  decimal point, active low
- digits  output  16  converted BCD {hi_tens, hi_ones, lo_tens, lo_ones}
- conv_done  output  1  one-cycle pulse when digits is updated

Behaviour:
- Reset (clear=1 at a rising edge) produces:
  - FSM in LOAD; scan counter 0; digit index 0.
  - digits=16'h0000, conv_done=0.
  - an=4'b1110, seg=7'b1000000 (glyph "0"), dp=1.
- clear has priority over every other event. Asserting it mid-conversion aborts the conversion; the partial result is discarded.
- Conversion FSM runs continuously, 8 cycles per pass:
  - LOAD (1 cycle): latch value_hi and value_lo into shift registers; zero both BCD scratch registers; go to SHIFT.
  - SHIFT (6 cycles, iteration counter 0..5):
    - For each field, any scratch nibble >=5 gets +3.
    - Then shift {scratch, binary} left by 1.
    - After iteration 5, go to UPDATE.
  - UPDATE (1 cycle): copy both scratch results to digits; pulse conv_done=1 for this cycle only; go to LOAD.
- Timing:
  - Inputs are sampled only in LOAD. Changes during SHIFT/UPDATE are seen on the next pass.
  - Worst-case input-to-digits latency is 16 cycles.
  - The first conv_done is 8 cycles after clear deasserts.
- Range:
  - Max input 63 gives tens=6, so no nibble can exceed 9.
  - Decoder maps BCD codes 10..15 to blank (seg=7'b1111111) as a defensive default.
- Scan:
  - Scan counter counts 0..SCAN_DIV-1 and wraps.
  - At the terminal count the digit index increments 0->1->2->3->0.
  - Index 0 = lo_ones (an=1110), 1 = lo_tens (1101), 2 = hi_ones (1011), 3 = hi_tens (0111).
- Outputs an, seg and dp are registered: they reflect the index and digits from the previous cycle (1-cycle latency). No glitch is allowed between index change and seg change; both update on the same edge.
- dp=0 only when the active digit is index 2 and dp_en=1; otherwise dp=1.
- Segment decode, active low, gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Leading zeros are displayed, not blanked.

Test Plan:
- Reset: hold clear 3 cycles with random inputs, then release -> an=1110, seg=1000000, dp=1, digits=0000 at release. conv_done first pulses 8 cycles later.
- Conversion: value_hi=59, value_lo=7 held -> within 16 cycles digits=16'h5907, and conv_done pulses every 8 cycles thereafter. Then apply 63/0 -> 16'h6300. Then 0/0 -> 16'h0000.
- Scan wrap (SCAN_DIV=4), digits=16'h1234:
  - an steps 1110,1101,1011,0111,1110, each held 4 cycles.
  - seg shows 4,3,2,1 glyphs (0011001, 0110000, 0100100, 1111001) in step with an.
- Mid-conversion clear: change value_lo to 42, then assert clear during SHIFT iteration 3 -> digits=0000 and no conv_done that pass. The next full pass yields lo field 42 (16'h0042 with value_hi=0).
- Decimal point: dp_en=1 -> dp=0 only while an=1011. dp_en=0 -> dp stays 1 for a full scan cycle.
- Decoder sweep: value_lo=0..9 in turn with index forced to 0 -> seg matches the ten patterns listed above exactly.
